vmem_burst_responder: RTL and testbench
=======================================

# vmem_burst_responder

Memory-side responder for the vector memory-interface burst protocol. It accepts one read or write burst from the vector requestor, sequences it beat by beat onto a single-port synchronous SRAM, and returns read beats through a backpressured `rddata` / `rddatavalid` / `rddataready` handshake. A small response FIFO with credit-based issue keeps one beat per cycle under continuous `rddataready`. It replaces the behavioural memory model at the far end of the requestor link.

## Interface
- `ADDR_RANGE`, default 32768: memory depth in words; address width `AW = $clog2(ADDR_RANGE)`.
- `LENGTH_RANGE`, default 32: maximum beats per burst; length width `$clog2(LENGTH_RANGE)+1`.
- `BUS_WIDTH`, default 32: beat and memory word width.
- `FIFO_DEPTH`, default 2: response FIFO entries; minimum 2.

Ports:
- `clk`  in  1  Single clock.
- `rst`  in  1  Asynchronous reset, active-low.
- `rd`  in  1  Read request pulse; sampled only while `ready`.
- `wr`  in  1  Write request pulse; sampled only while `ready`.
- `addr`  in  AW  Burst start word address.
- `length`  in  `$clog2(LENGTH_RANGE)+1`  Beat count.
- `mode_in`  in  2  Address mode: 00 incrementing, 01 fixed, 10 and 11 treated as 00.
- `wrdata`  in  BUS_WIDTH  Write beat.
- `ready`  out  1  Idle; a request may be presented.
- `rddata`  out  BUS_WIDTH  Read beat (FIFO head).
- `rddatavalid`  out  1  `rddata` is valid.
- `rddataready`  in  1  Requestor accepts the beat.
- `mem_rd`  out  1  SRAM read strobe.
- `mem_wr`  out  1  SRAM write strobe.
- `mem_addr`  out  AW  SRAM address.
- `mem_wdata`  out  BUS_WIDTH  SRAM write data.
- `mem_rdata`  in  BUS_WIDTH  SRAM read data, valid the cycle after `mem_rd`.

## Operation
- States: IDLE, WRITE, READ, DRAIN.
  - `ready = (state == IDLE)`.
- **Accept:** in IDLE, `rd` or `wr` high at a rising edge.
  - Latch `addr`, mode and effective length: `min(length, LENGTH_RANGE)`.
  - `wr` has priority when both are high.
  - Length 0: accepted with no memory activity; the block stays in IDLE.
- **WRITE:**
  - Beat k of `wrdata` is sampled k+1 cycles after the accept edge.
  - Each beat drives `mem_wr=1`, `mem_addr` = current address, `mem_wdata` = `wrdata` combinationally.
  - After the last beat, return to IDLE.
- **READ:**
  - Issue `mem_rd` at the current address when `occ + inflight − pop < FIFO_DEPTH`.
    - `inflight` (0/1) is `mem_rd` from the previous cycle.
    - `pop = rddatavalid & rddataready`.
  - `mem_rdata` is written into the FIFO at the end of the cycle after `mem_rd`.
  - After the last issue, go to DRAIN.
- **DRAIN:** go to IDLE once `inflight == 0` and the FIFO is empty.
- **Address update:** after each issued beat, incrementing mode adds 1 modulo `ADDR_RANGE` (wraps from `ADDR_RANGE−1` to 0); fixed mode holds the address.
- **Handshake:** `rddatavalid` = FIFO non-empty, and `rddata` = FIFO head.
  - The head holds stable while `rddatavalid` is high and `rddataready` is low.
  - Push and pop in the same cycle keeps occupancy unchanged.
  - Overflow is impossible by credit; overflow or underflow is a simulation assertion.
- **Reset mid-burst:** state returns to IDLE, the FIFO is flushed, and inflight is cleared.
  - Any `mem_rdata` returning after reset release is ignored.

## Timing
- Reset values: `ready=1`, `rddatavalid=0`, `rddata=0`, `mem_rd=0`, `mem_wr=0`, `mem_addr=0`, `mem_wdata=0`.
- Read latency (accept edge = cycle 0):
  - `mem_rd` beat 0 in cycle 1.
  - `mem_rdata` in cycle 2.
  - `rddatavalid` in cycle 3.
- Read throughput: with `rddataready` held high, one beat per cycle from cycle 3 to cycle `length+2`; `ready` rises in cycle `length+3`.
- Write: `mem_wr` in cycles 1..length; `ready` in cycle `length+1`.
- `rddataready` low stalls issue within one cycle; at most `FIFO_DEPTH` beats are buffered.

## Structure
- `vmem_pkg`: `state_t` enum (IDLE/WRITE/READ/DRAIN) and `mode_t` enum (`MODE_INCR=2'b00`, `MODE_FIXED=2'b01`).
- Sub-module `vmem_resp_fifo`: synchronous FIFO, parameters `WIDTH` and `DEPTH`, ports push/pop/full/empty/count and the same active-low asynchronous reset.
- Responder top: FSM, beat counter, address counter, credit logic.

## Test plan
- **Incrementing read:** preload mem[i]=i+0x100; read addr=4, len=8, `rddataready=1` → beats 0x104..0x10B on cycles 3..10, `ready` in cycle 11.
- **Write then read back:** write addr=0x20, len=4, wrdata 0xA0..0xA3 → `mem_wr` cycles 1..4 at 0x20..0x23; readback returns 0xA0..0xA3.
- **Backpressure:** read len=6 with `rddataready` toggling 1,0,0,1 → all six beats delivered in order; `rddata` stable while stalled; FIFO occupancy never exceeds 2.
- **Boundaries:**
  - Incrementing read at addr=32767, len=3 → addresses 32767, 0, 1.
  - Fixed-mode read, len=4 → four beats from one address.
  - len=0 → no `mem_rd`/`mem_wr`; `ready` stays 1.
  - len=40 → clamped to 32 beats.
- **Edge cases:**
  - `rd` and `wr` high together → write performed.
  - `rst` asserted during beat 3 of an 8-beat read → outputs take reset values immediately; after release, `ready=1` and no stale `rddatavalid`.

Source files
------------

// File: rtl/vmem_pkg.sv
// Shared types for the vector memory burst responder.
//   state_t : responder FSM states
//   mode_t  : burst address modes (encodings 2'b10/2'b11 behave as incrementing)
package vmem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        MODE_INCR  = 2'b00,
        MODE_FIXED = 2'b01
    } mode_t;

endpackage

// File: rtl/vmem_resp_fifo.sv
// Small synchronous response FIFO for read beats.
//   clk, rst (async, active-low) : clock / reset
//   push, wdata                  : write side
//   pop, rdata                   : read side; rdata is the head, forced to 0 while empty
//   full, empty, count           : occupancy status
module vmem_resp_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    // Head is masked while empty so the output reads 0 out of reset.
    assign rdata = empty ? '0 : mem_q[rptr_q];

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) begin
            wptr_d = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + PW'(1);
        end
        if (do_pop) begin
            rptr_d = (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + PW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: reads are masked by empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!(push && full && !pop));
            assert (!(pop && empty));
        end
    end

endmodule

// File: rtl/vmem_burst_responder.sv
// Memory-side burst responder: takes one read/write burst, sequences it onto a
// single-port synchronous SRAM and returns read beats through a backpressured
// rddata/rddatavalid/rddataready handshake.
//   clk, rst (async, active-low)
//   rd, wr, addr, length, mode_in, wrdata : request side (sampled while ready)
//   ready                                 : idle, request may be presented
//   rddata, rddatavalid, rddataready      : read beat return
//   mem_rd, mem_wr, mem_addr, mem_wdata   : SRAM command
//   mem_rdata                             : SRAM data, one cycle after mem_rd
module vmem_burst_responder
    import vmem_pkg::*;
#(
    parameter int unsigned ADDR_RANGE   = 32768,
    parameter int unsigned LENGTH_RANGE = 32,
    parameter int unsigned BUS_WIDTH    = 32,
    parameter int unsigned FIFO_DEPTH   = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              rd,
    input  logic                              wr,
    input  logic [$clog2(ADDR_RANGE)-1:0]     addr,
    input  logic [$clog2(LENGTH_RANGE):0]     length,
    input  logic [1:0]                        mode_in,
    input  logic [BUS_WIDTH-1:0]              wrdata,
    output logic                              ready,
    output logic [BUS_WIDTH-1:0]              rddata,
    output logic                              rddatavalid,
    input  logic                              rddataready,
    output logic                              mem_rd,
    output logic                              mem_wr,
    output logic [$clog2(ADDR_RANGE)-1:0]     mem_addr,
    output logic [BUS_WIDTH-1:0]              mem_wdata,
    input  logic [BUS_WIDTH-1:0]              mem_rdata
);

    localparam int unsigned AW = $clog2(ADDR_RANGE);
    localparam int unsigned LW = $clog2(LENGTH_RANGE) + 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d, addr_next;
    logic [LW-1:0] cnt_q, cnt_d, len_eff;
    logic          fixed_q, fixed_d;
    logic          inflight_q;
    logic [CW-1:0] occ;
    logic          fifo_full, fifo_empty;
    logic          pop;
    logic          credit;

    assign ready       = (state_q == IDLE);
    assign rddatavalid = !fifo_empty;
    assign pop         = rddatavalid && rddataready;

    assign len_eff = (length > LW'(LENGTH_RANGE)) ? LW'(LENGTH_RANGE) : length;

    // Explicit wrap so non power-of-two memory depths also work.
    assign addr_next = fixed_q ? addr_q :
                       (addr_q == AW'(ADDR_RANGE - 1)) ? '0 : addr_q + AW'(1);

    // A beat may issue only if it is guaranteed a FIFO slot when it returns.
    assign credit = (int'(occ) + int'(inflight_q)) < (int'(FIFO_DEPTH) + int'(pop));

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        fixed_d   = fixed_q;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            IDLE: begin
                // Zero-length requests are swallowed without leaving IDLE.
                if ((rd || wr) && (len_eff != '0)) begin
                    addr_d  = addr;
                    cnt_d   = len_eff;
                    fixed_d = (mode_in == MODE_FIXED);
                    state_d = wr ? WRITE : READ;
                end
            end
            WRITE: begin
                mem_wr    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wrdata;
                addr_d    = addr_next;
                cnt_d     = cnt_q - LW'(1);
                if (cnt_q == LW'(1)) begin
                    state_d = IDLE;
                end
            end
            READ: begin
                mem_addr = addr_q;
                if (credit) begin
                    mem_rd = 1'b1;
                    addr_d = addr_next;
                    cnt_d  = cnt_q - LW'(1);
                    if (cnt_q == LW'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Leave as the last beat is popped so ready rises the next cycle.
                if (!inflight_q && (fifo_empty || ((occ == CW'(1)) && pop))) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            fixed_q    <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            fixed_q    <= fixed_d;
            inflight_q <= mem_rd;
        end
    end

    vmem_resp_fifo #(
        .WIDTH (BUS_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight_q),
        .wdata (mem_rdata),
        .pop   (pop),
        .rdata (rddata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (occ)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!(inflight_q && fifo_full && !pop));
        end
    end

endmodule

// File: tb/tb_vmem_burst_responder.sv
// Bench for vmem_burst_responder: SRAM model plus a reference memory image;
// expected beats and addresses come from the burst rules applied to that image.
module tb_vmem_burst_responder;

    localparam int AR = 32768;
    localparam int LR = 32;
    localparam int FD = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd, wr;
    logic [14:0] addr;
    logic [5:0]  length;
    logic [1:0]  mode_in;
    logic [31:0] wrdata;
    logic        ready;
    logic [31:0] rddata;
    logic        rddatavalid;
    logic        rddataready;
    logic        mem_rd, mem_wr;
    logic [14:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] sram    [AR];
    logic [31:0] ref_mem [AR];

    always #5 clk = ~clk;

    vmem_burst_responder #(
        .ADDR_RANGE   (AR),
        .LENGTH_RANGE (LR),
        .BUS_WIDTH    (32),
        .FIFO_DEPTH   (FD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rd          (rd),
        .wr          (wr),
        .addr        (addr),
        .length      (length),
        .mode_in     (mode_in),
        .wrdata      (wrdata),
        .ready       (ready),
        .rddata      (rddata),
        .rddatavalid (rddatavalid),
        .rddataready (rddataready),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    // Single-port synchronous SRAM, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_wr) sram[mem_addr] <= mem_wdata;
        if (mem_rd) mem_rdata <= sram[mem_addr];
    end

    function automatic int beat_addr(input int a, input int i, input logic [1:0] m);
        return (m == 2'b01) ? a : (a + i) % AR;
    endfunction

    function automatic logic rr_val(input int rr_mode, input int k);
        logic [3:0] pat;
        pat = 4'b1001;
        if (rr_mode == 0) return 1'b1;
        if (rr_mode == 1) return pat[3 - ((k - 1) % 4)];
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic issue(input logic r, input logic w, input int a, input int len,
                         input logic [1:0] m);
        @(negedge clk);
        rd = r; wr = w; addr = 15'(a); length = 6'(len); mode_in = m;
        @(posedge clk);
        #1;
        rd = 1'b0; wr = 1'b0;
    endtask

    task automatic run_read(input int a, input int len, input logic [1:0] m,
                            input int rr_mode, input bit chk_timing);
        int          leff;
        logic [31:0] exp_data [$];
        int          exp_addr [$];
        int          k, first_c, last_c, ready_c, issued, popped, iss_c1, iss_c2, ea;
        bit          done, prev_stall;
        logic [31:0] prev_data, ed;
        leff = (len > LR) ? LR : len;
        first_c = -1; last_c = -1; ready_c = -1;
        issued = 0; popped = 0; iss_c1 = 0; iss_c2 = 0;
        done = 0; prev_stall = 0; prev_data = '0;
        for (int i = 0; i < leff; i++) begin
            exp_addr.push_back(beat_addr(a, i, m));
            exp_data.push_back(ref_mem[beat_addr(a, i, m)]);
        end
        issue(1'b1, 1'b0, a, len, m);
        k = 1;
        rddataready = rr_val(rr_mode, k);
        while (!done && k < 300) begin
            @(negedge clk);
            n_checks++;
            if (iss_c2 - popped > FD) begin
                n_fail++;
                $display("FAIL occupancy cycle %0d: buffered %0d, limit %0d", k,
                         iss_c2 - popped, FD);
            end
            if (prev_stall) begin
                n_checks++;
                if (rddatavalid !== 1'b1 || rddata !== prev_data) begin
                    n_fail++;
                    $display("FAIL stall_hold cycle %0d: valid %b data %h, expected 1 %h",
                             k, rddatavalid, rddata, prev_data);
                end
            end
            if (mem_rd === 1'b1) begin
                n_checks++;
                if (exp_addr.size() == 0) begin
                    n_fail++;
                    $display("FAIL extra_mem_rd cycle %0d: addr %0d, expected no read",
                             k, mem_addr);
                end else begin
                    ea = exp_addr.pop_front();
                    if (int'(mem_addr) != ea) begin
                        n_fail++;
                        $display("FAIL mem_addr cycle %0d: got %0d, expected %0d",
                                 k, mem_addr, ea);
                    end
                end
                issued++;
            end
            if (rddatavalid === 1'b1 && rddataready) begin
                n_checks++;
                if (exp_data.size() == 0) begin
                    n_fail++;
                    $display("FAIL extra_beat cycle %0d: got %h, expected none", k, rddata);
                end else begin
                    ed = exp_data.pop_front();
                    if (rddata !== ed) begin
                        n_fail++;
                        $display("FAIL rddata cycle %0d: got %h, expected %h", k, rddata, ed);
                    end
                end
                if (first_c < 0) first_c = k;
                last_c = k;
                popped++;
            end
            prev_stall = (rddatavalid === 1'b1) && !rddataready;
            prev_data  = rddata;
            if (ready === 1'b1) begin
                done    = 1;
                ready_c = k;
            end
            iss_c2 = iss_c1;
            iss_c1 = issued;
            if (!done) begin
                @(posedge clk);
                #1;
                k++;
                rddataready = rr_val(rr_mode, k);
            end
        end
        rddataready = 1'b1;
        n_checks++;
        if (!done || exp_data.size() != 0 || exp_addr.size() != 0) begin
            n_fail++;
            $display("FAIL read_complete a=%0d len=%0d: done %0d, beats left %0d, addrs left %0d, expected 1 0 0",
                     a, len, done, exp_data.size(), exp_addr.size());
        end
        if (chk_timing) begin
            n_checks++;
            if (first_c != 3 || last_c != leff + 2 || ready_c != leff + 3) begin
                n_fail++;
                $display("FAIL read_timing len=%0d: first %0d last %0d ready %0d, expected 3 %0d %0d",
                         len, first_c, last_c, ready_c, leff + 2, leff + 3);
            end
        end
    endtask

    task automatic run_write(input int a, input int len, input logic [1:0] m, input logic r_too);
        int          leff, ea;
        logic [31:0] wd [$];
        leff = (len > LR) ? LR : len;
        for (int i = 0; i < leff; i++) wd.push_back($urandom);
        issue(r_too, 1'b1, a, len, m);
        for (int k = 1; k <= leff + 1; k++) begin
            wrdata = (k <= leff) ? wd[k-1] : $urandom;
            @(negedge clk);
            n_checks++;
            if (k <= leff) begin
                ea = beat_addr(a, k - 1, m);
                if (mem_wr !== 1'b1 || int'(mem_addr) != ea || mem_wdata !== wd[k-1]
                    || ready !== 1'b0 || mem_rd !== 1'b0) begin
                    n_fail++;
                    $display("FAIL write_beat %0d: wr %b addr %0d data %h ready %b rd %b, expected 1 %0d %h 0 0",
                             k, mem_wr, mem_addr, mem_wdata, ready, mem_rd, ea, wd[k-1]);
                end
                @(posedge clk);
                #1;
            end else begin
                if (ready !== 1'b1 || mem_wr !== 1'b0) begin
                    n_fail++;
                    $display("FAIL write_end cycle %0d: ready %b wr %b, expected 1 0",
                             k, ready, mem_wr);
                end
            end
        end
        for (int i = 0; i < leff; i++) ref_mem[beat_addr(a, i, m)] = wd[i];
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        n_checks++;
        if (ready !== 1'b1 || rddatavalid !== 1'b0 || rddata !== 32'h0 || mem_rd !== 1'b0
            || mem_wr !== 1'b0 || mem_addr !== 15'h0 || mem_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_values: ready %b valid %b data %h rd %b wr %b addr %h wdata %h, expected 1 0 0 0 0 0 0",
                     ready, rddatavalid, rddata, mem_rd, mem_wr, mem_addr, mem_wdata);
        end
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_incr_read();
        run_read(4, 8, 2'b00, 0, 1);
    endtask

    task automatic test_write_readback();
        logic [31:0] d;
        issue(1'b0, 1'b1, 32'h20, 4, 2'b00);
        for (int k = 1; k <= 5; k++) begin
            d = 32'hA0 + 32'(k - 1);
            wrdata = d;
            @(negedge clk);
            n_checks++;
            if (k <= 4) begin
                if (mem_wr !== 1'b1 || mem_addr !== 15'(32'h20 + k - 1) || mem_wdata !== d) begin
                    n_fail++;
                    $display("FAIL wb_beat %0d: wr %b addr %h data %h, expected 1 %h %h",
                             k, mem_wr, mem_addr, mem_wdata, 15'(32'h20 + k - 1), d);
                end
                ref_mem[32'h20 + k - 1] = d;
                @(posedge clk);
                #1;
            end else if (ready !== 1'b1) begin
                n_fail++;
                $display("FAIL wb_ready: got %b, expected 1", ready);
            end
        end
        run_read(32'h20, 4, 2'b00, 0, 1);
    endtask

    task automatic test_backpressure();
        run_read(32'h50, 6, 2'b00, 1, 0);
        run_read($urandom_range(0, AR - 1), 9, 2'b00, 2, 0);
    endtask

    task automatic test_boundaries();
        run_read(AR - 1, 3, 2'b00, 0, 1);
        run_read(32'h30, 4, 2'b01, 0, 1);
        run_read(32'h100, 40, 2'b00, 0, 1);
        run_read(AR - 2, 4, 2'b10, 0, 1);
    endtask

    task automatic test_len_zero();
        for (int j = 0; j < 2; j++) begin
            issue(j == 0, j == 1, 32'h40, 0, 2'b00);
            for (int k = 1; k <= 3; k++) begin
                @(negedge clk);
                n_checks++;
                if (ready !== 1'b1 || mem_rd !== 1'b0 || mem_wr !== 1'b0) begin
                    n_fail++;
                    $display("FAIL len_zero cycle %0d: ready %b rd %b wr %b, expected 1 0 0",
                             k, ready, mem_rd, mem_wr);
                end
            end
        end
    endtask

    task automatic test_rd_wr_both();
        run_write(32'h200, 3, 2'b00, 1'b1);
        run_read(32'h200, 3, 2'b00, 0, 1);
    endtask

    task automatic test_random();
        int a, len;
        logic [1:0] m;
        for (int it = 0; it < 10; it++) begin
            a   = $urandom_range(0, AR - 1);
            len = $urandom_range(1, 12);
            m   = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) run_write(a, len, m, 1'b0);
            else if ((it % 2) == 0) run_read(a, len, m, 0, 1);
            else run_read(a, len, m, 2, 0);
        end
    endtask

    task automatic test_reset_midburst();
        rddataready = 1'b1;
        issue(1'b1, 1'b0, 32'h40, 8, 2'b00);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        n_checks++;
        if (mem_rd !== 1'b1 || mem_addr !== 15'h43) begin
            n_fail++;
            $display("FAIL midburst_beat3: rd %b addr %h, expected 1 0043", mem_rd, mem_addr);
        end
        #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if (ready !== 1'b1 || rddatavalid !== 1'b0 || rddata !== 32'h0 || mem_rd !== 1'b0
            || mem_wr !== 1'b0 || mem_addr !== 15'h0 || mem_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL midburst_reset: ready %b valid %b data %h rd %b wr %b addr %h wdata %h, expected 1 0 0 0 0 0 0",
                     ready, rddatavalid, rddata, mem_rd, mem_wr, mem_addr, mem_wdata);
        end
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++;
            if (ready !== 1'b1 || rddatavalid !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset cycle %0d: ready %b valid %b, expected 1 0",
                         k, ready, rddatavalid);
            end
        end
        run_read(32'h40, 2, 2'b00, 0, 1);
    endtask

    initial begin
        rd = 1'b0; wr = 1'b0; addr = '0; length = '0; mode_in = '0;
        wrdata = '0; rddataready = 1'b1; rst = 1'b0;
        for (int i = 0; i < AR; i++) begin
            sram[i]    = 32'(i) + 32'h100;
            ref_mem[i] = 32'(i) + 32'h100;
        end
        test_reset();
        test_incr_read();
        test_write_readback();
        test_backpressure();
        test_boundaries();
        test_len_zero();
        test_rd_wr_both();
        test_random();
        test_reset_midburst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
